// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 engine: folds up to KEEP_W kept bytes per beat and
// presents the FCS (generate) or residue verdict (check) one cycle after in_last.

module crc32_stream_byte (
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  input  logic        i_en,
  output logic [31:0] o_crc
);
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc ^ {24'h0, i_byte};
    for (int b = 0; b < 8; b++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ POLY) : (w_c >> 1);
    end
    o_crc = i_en ? w_c : i_crc;
  end
endmodule

module crc32_stream #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              mode_chk,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_crc,
  output logic              out_ok,
  output logic              out_err,
  output logic [CNT_W-1:0]  out_bytes
);
  localparam logic [31:0]       CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0]       RESIDUE  = 32'hDEBB20E3;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [KEEP_W-1:0] KEEP_ALL = {KEEP_W{1'b1}};
  localparam int POP_W = $clog2(KEEP_W + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_crc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_mode;
  logic [31:0]       r_out_crc;
  logic              r_out_ok;
  logic              r_out_err;
  logic [CNT_W-1:0]  r_out_bytes;

  logic [31:0]       w_chain [KEEP_W+1];
  logic              w_accept;
  logic              w_first;
  logic              w_mode;
  logic [POP_W-1:0]  w_pop;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_keep_contig;
  logic              w_keep_bad;
  logic              w_err_nxt;
  logic [31:0]       w_crc_nxt;

  // Byte lanes chained in wire order; disabled lanes pass the state through.
  assign w_chain[0] = r_crc;
  for (genvar g = 0; g < KEEP_W; g++) begin : g_lane
    crc32_stream_byte u_lane (
      .i_crc  (w_chain[g]),
      .i_byte (in_data[8*g +: 8]),
      .i_en   (in_keep[g]),
      .o_crc  (w_chain[g+1])
    );
  end
  assign w_crc_nxt = w_chain[KEEP_W];

  assign in_ready  = (r_state != HOLD) | out_ready;
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid & in_ready & ~clr;
  assign w_first   = (r_state != ACC);
  assign w_mode    = w_first ? mode_chk : r_mode;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < KEEP_W; k++) w_pop = w_pop + POP_W'(in_keep[k]);
  end

  assign w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pop);
  assign w_cnt_nxt = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

  // Low-contiguous mask (incl. zero): adding one clears every set bit.
  assign w_keep_contig = ((in_keep & (in_keep + KEEP_W'(1))) == '0);
  assign w_keep_bad    = in_last ? ~w_keep_contig : (in_keep != KEEP_ALL);
  assign w_err_nxt     = r_err | w_keep_bad;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = in_last ? HOLD : ACC;
      ACC:  if (w_accept && in_last) w_state_nxt = HOLD;
      HOLD: if (out_ready) begin
        if (w_accept) w_state_nxt = in_last ? HOLD : ACC;
        else          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clr) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Accumulators return to init on frame close so the next first beat needs no mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc  <= CRC_INIT;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_mode <= 1'b0;
    end else if (clr) begin
      r_crc  <= CRC_INIT;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_mode <= w_mode;
      if (in_last) begin
        r_crc <= CRC_INIT;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        r_crc <= w_crc_nxt;
        r_cnt <= w_cnt_nxt;
        r_err <= w_err_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_crc   <= '0;
      r_out_ok    <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_bytes <= '0;
    end else if (!clr && w_accept && in_last) begin
      r_out_crc   <= ~w_crc_nxt;
      r_out_ok    <= w_mode & (w_crc_nxt == RESIDUE);
      r_out_err   <= w_err_nxt;
      r_out_bytes <= w_cnt_nxt;
    end
  end

  assign out_crc   = r_out_crc;
  assign out_ok    = r_out_ok;
  assign out_err   = r_out_err;
  assign out_bytes = r_out_bytes;
endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Sequential, parametrised CRC-32 engine for the LMAC datapath.
- Accumulates an Ethernet CRC-32 (IEEE 802.3, polynomial 0x04C11DB7) over a multi-beat frame presented on a valid/ready stream with per-byte keep.
- Generate mode: returns the FCS to append on TX.
- Check mode: tests the received frame-plus-FCS residue on RX.
- Replaces fixed 64-bit, data-only combinational folding with a width-generic, stateful, byte-granular engine.

Parameters:
- DATA_W, 64, stream data width in bits; multiple of 8, range 8..128.
- KEEP_W, DATA_W/8, byte-enable width; derived, not overridden.
- CNT_W, 16, frame byte-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort: discard the in-progress frame and any pending result
- mode_chk  in  1  0 = generate, 1 = check; sampled on the first beat of each frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  DATA_W  byte k = in_data[8k+7:8k]; byte 0 is first on the wire
- in_keep  in  KEEP_W  byte enables
- in_last  in  1  final beat of frame
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_crc  out  32  ~crc_state; FCS byte order is out_crc[7:0] first
- out_ok  out  1  check mode: crc_state == 32'hDEBB20E3; 0 in generate mode
- out_err  out  1  sticky keep-protocol violation seen in this frame
- out_bytes  out  CNT_W  number of kept bytes in frame, saturating at all-ones

Behaviour:
- Reset (rst_n=0, asynchronous) values:
  - state IDLE; crc_state = 32'hFFFFFFFF; byte count 0; err 0.
  - out_valid 0, out_crc 0, out_ok 0, out_err 0, out_bytes 0; in_ready 1.
- CRC arithmetic:
  - Reflected form: shift right, polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Each kept byte is folded LSB-first, in byte order 0..KEEP_W-1, all within one cycle.
  - The per-beat next-state is a combinational function of crc_state, in_data and in_keep.
- Handshake:
  - in_ready = (state != HOLD) | out_ready.
  - A beat is accepted only on in_valid & in_ready.
  - in_data, in_keep and in_last are ignored otherwise.
- States:
  - IDLE: no frame open. An accepted beat starts a frame from init state, latches mode_chk, and goes to ACC. If in_last is also set (single-beat frame), go straight to HOLD.
  - ACC: each accepted beat folds its kept bytes and adds popcount(in_keep) to the count. An accepted beat with in_last goes to HOLD.
  - HOLD: out_valid=1 with outputs stable until out_ready.
    - On out_ready: go to IDLE, or directly start the next frame if a beat is accepted in the same cycle (no bubble).
- Latency: out_valid asserts exactly 1 cycle after the in_last beat is accepted. Sustained throughput is 1 beat/cycle when out_ready=1.
- Keep rules:
  - Non-last beats must have keep all-ones.
  - Last beats must be low-contiguous (including 0).
  - A violation sets err. Only the asserted bytes are still folded and counted; there is no stall.
- keep=0 with in_last=1 is legal and closes the frame without adding bytes.
- Byte counter saturates at 2^CNT_W-1 and does not wrap.
- clr:
  - Has priority over any same-cycle beat; that beat is dropped.
  - Returns to IDLE with init state, out_valid=0, count 0, err 0.
  - A pending HOLD result is lost.
- Asynchronous reset mid-frame or in HOLD behaves the same as clr, without requiring a clock edge.
- Result outputs hold their last values when out_valid=0; they are only meaningful while out_valid=1.

Test Plan:
- DATA_W=64, generate mode, "123456789":
  - Stimulus: beat0 data=0x3837363534333231 keep=0xFF; beat1 data=0x39 keep=0x01 last=1.
  - Expect: out_crc=0xCBF43926, out_bytes=9, out_err=0, one cycle after beat1.
- Check mode:
  - Stimulus: same beat0; beat1 data=0xCBF4392639 keep=0x1F last=1.
  - Expect: out_ok=1, out_crc=0x2144DF1C, out_bytes=13.
  - Flip bit 0 of beat1 and resend: out_ok=0.
- Backpressure and back-to-back:
  - Stimulus: two frames sent back-to-back with out_ready=0 for 3 cycles.
  - Expect: in_ready=0 while HOLD is pending, first result held stable.
  - Release out_ready: second frame starts the same cycle, both CRCs correct, no bubble.
- Keep violations:
  - Stimulus: non-last beat with keep=0x7F; separately, last beat with keep=0x05.
  - Expect: out_err=1 for each frame.
  - Then send a clean frame: out_err=0.
- Boundaries:
  - Stimulus: single beat with keep=0 and last=1.
  - Expect: out_crc=0x00000000, out_bytes=0.
  - DATA_W=8 build with "123456789": out_crc=0xCBF43926.
  - CNT_W=4 build with 20 bytes: out_bytes=15.
- Abort and reset:
  - Stimulus: clr asserted mid-frame, then "123456789" sent.
  - Expect: out_crc=0xCBF43926, with no prefix contamination.
  - rst_n pulsed low during HOLD: out_valid=0 immediately, without a clock edge.
